// File: rtl/xpb_lut_accum.sv
// Runtime-loadable XPB residue tables: one table per segment, one read per cycle,
// returning the un-reduced sum of the entries selected by a packed index vector.
module xpb_lut_accum #(
  parameter int WORD_BITS = 1024,
  parameter int IDX_BITS  = 5,
  parameter int NUM_SEG   = 8,
  localparam int SEG_BITS = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  parameter int SUM_BITS  = WORD_BITS + ((NUM_SEG > 1) ? $clog2(NUM_SEG) : 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  output logic                         wr_ready,
  input  logic [SEG_BITS-1:0]          wr_seg,
  input  logic [IDX_BITS-1:0]          wr_idx,
  input  logic [WORD_BITS-1:0]         wr_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SEG*IDX_BITS-1:0]  in_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_BITS-1:0]          out_sum,
  output logic [1:0]                   dbg_state  // 0 IDLE, 1 READ, 2 DRAIN, 3 DONE
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high at
  // posedge. Valid never depends on ready; out_valid/out_sum hold until out_ready.

  localparam int ADDR_BITS = SEG_BITS + IDX_BITS;
  localparam int TBL_DEPTH = 2 ** ADDR_BITS;
  localparam logic [SEG_BITS-1:0] LAST_SEG = SEG_BITS'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [NUM_SEG*IDX_BITS-1:0]   idx_q, idx_d;
  logic [SEG_BITS-1:0]           seg_cnt_q, seg_cnt_d;
  logic [SUM_BITS-1:0]           acc_q, acc_d;
  logic                          add_en_q, add_en_d;
  logic [WORD_BITS-1:0]          rdata_q;
  logic [IDX_BITS-1:0]           cur_idx;
  logic [ADDR_BITS-1:0]          rd_addr;
  logic [ADDR_BITS-1:0]          wr_addr;
  logic                          rd_en;
  logic                          wr_fire;
  logic                          in_fire;

  logic [WORD_BITS-1:0]          tbl_mem [TBL_DEPTH];

  assign wr_ready  = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_IDLE) && !wr_en;
  assign wr_fire   = wr_en && wr_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = acc_q;
  assign dbg_state = state_q;

  assign cur_idx = idx_q[int'(seg_cnt_q)*IDX_BITS +: IDX_BITS];
  assign rd_addr = {seg_cnt_q, cur_idx};
  assign wr_addr = {wr_seg, wr_idx};
  assign rd_en   = (state_q == S_READ);

  // Table contents survive reset so a reset does not force a modulus reload.
  always_ff @(posedge clk) begin
    if (wr_fire) tbl_mem[wr_addr] <= wr_data;
    if (rd_en)   rdata_q <= tbl_mem[rd_addr];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seg_cnt_d = seg_cnt_q;
    add_en_d  = 1'b0;
    acc_d     = add_en_q ? (acc_q + SUM_BITS'(rdata_q)) : acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          idx_d     = in_idx;
          acc_d     = '0;
          seg_cnt_d = '0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        // rdata_q lands one cycle after the read; add_en_q tracks that lag.
        add_en_d = 1'b1;
        if (seg_cnt_q == LAST_SEG) state_d = S_DRAIN;
        else                       seg_cnt_d = seg_cnt_q + SEG_BITS'(1);
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      seg_cnt_q <= '0;
      acc_q     <= '0;
      add_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seg_cnt_q <= seg_cnt_d;
      acc_q     <= acc_d;
      add_en_q  <= add_en_d;
    end
  end

endmodule

// File: tb/tb_xpb_lut_accum.sv
// Bench for xpb_lut_accum: small 16-bit/4-segment instance plus a default-parameter instance.
module tb_xpb_lut_accum;

  localparam int W  = 16;
  localparam int IB = 2;
  localparam int NS = 4;
  localparam int SB = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_ready, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    wr_seg, wr_idx, dbg_state;
  logic [W-1:0]  wr_data;
  logic [7:0]    in_idx;
  logic [SB-1:0] out_sum;

  logic          b_wr_en, b_wr_ready, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]    b_wr_seg;
  logic [4:0]    b_wr_idx;
  logic [1023:0] b_wr_data;
  logic [39:0]   b_in_idx;
  logic [1026:0] b_out_sum;
  logic [1:0]    b_dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0]  ref_tbl [NS][2**IB];
  logic [SB-1:0] exp_q [$];

  typedef struct {
    logic [7:0]    idx;
    logic [SB-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  xpb_lut_accum #(.WORD_BITS(W), .IDX_BITS(IB), .NUM_SEG(NS)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ready(wr_ready), .wr_seg(wr_seg),
    .wr_idx(wr_idx), .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .dbg_state(dbg_state)
  );

  xpb_lut_accum u_big (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_ready(b_wr_ready), .wr_seg(b_wr_seg),
    .wr_idx(b_wr_idx), .wr_data(b_wr_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_idx(b_in_idx), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .dbg_state(b_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [1026:0] act, input logic [1026:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got (low 160b) %0h expected %0h", nm, act[159:0], exp[159:0]);
    end
  endtask

  function automatic logic [SB-1:0] model_sum(input logic [7:0] idx);
    logic [SB-1:0] s = '0;
    for (int k = 0; k < NS; k++) s += SB'(ref_tbl[k][idx[k*IB +: IB]]);
    return s;
  endfunction

  // driver tasks: all start and end just after a negedge
  task automatic wr(input int s, input int i, input logic [W-1:0] d);
    wr_en = 1'b1; wr_seg = 2'(s); wr_idx = 2'(i); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    ref_tbl[s][i] = d;
  endtask

  task automatic accept_req(input logic [7:0] idx, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1; in_idx = idx;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_idx = 8'($urandom);
  endtask

  task automatic collect(input string nm, input int hold, input int acc_cyc);
    logic [SB-1:0] e;
    e = exp_q.pop_front();
    while (!out_valid && (cyc - acc_cyc) < 40) @(negedge clk);
    if (!out_valid) begin
      chk({nm, "_timeout"}, out_valid, 1'b1);
      return;
    end
    chk({nm, "_lat"}, 32'(cyc - acc_cyc), NS + 2);
    chk({nm, "_sum"}, out_sum, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold"}, {out_valid, in_ready, out_sum}, {1'b1, 1'b0, e});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle"}, {out_valid, in_ready, dbg_state}, {1'b0, 1'b1, 2'd0});
  endtask

  task automatic run_req(input string nm, input logic [7:0] idx, input logic [SB-1:0] e,
                         input int hold);
    int a;
    exp_q.push_back(e);
    accept_req(idx, a);
    collect(nm, hold, a);
  endtask

  // main sequence
  initial begin
    int a, a2, tw;
    logic saw;
    logic [7:0] ri;
    logic [1026:0] big_exp;

    vecs[0] = '{8'h93, 18'h0A6};  // segs {3,0,1,2}: 19+32+49+66
    vecs[1] = '{8'h00, 18'h0A0};  // 16+32+48+64
    vecs[2] = '{8'hFF, 18'h0AC};  // 19+35+51+67
    vecs[3] = '{8'h55, 18'h0A4};  // 17+33+49+65
    vecs[4] = '{8'hAA, 18'h0A8};  // 18+34+50+66
    vecs[5] = '{8'h03, 18'h0A3};  // 19+32+48+64

    rst = 1'b1; wr_en = 0; wr_seg = 0; wr_idx = 0; wr_data = 0;
    in_valid = 0; in_idx = 0; out_ready = 0;
    b_wr_en = 0; b_wr_seg = 0; b_wr_idx = 0; b_wr_data = '0;
    b_in_valid = 0; b_in_idx = 0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", {dbg_state, out_valid, wr_ready, in_ready}, {2'd0, 1'b0, 1'b1, 1'b1});
    chk("rst_sum", out_sum, 18'h0);

    // table load and table-driven vectors
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 4; i++) wr(s, i, 16'((s + 1) * 16 + i));
    for (int v = 0; v < 6; v++) run_req($sformatf("vec%0d", v), vecs[v].idx, vecs[v].exp, 0);

    // backpressure: 10 cycles with out_ready low
    run_req("backpressure", 8'h93, 18'h0A6, 10);

    // write and request in the same IDLE cycle: write wins, request next cycle
    wr_en = 1'b1; wr_seg = 2'd0; wr_idx = 2'd2; wr_data = 16'h1234;
    in_valid = 1'b1; in_idx = 8'h02;
    #1;
    chk("prio_in_ready", {wr_ready, in_ready}, {1'b1, 1'b0});
    tw = cyc;
    ref_tbl[0][2] = 16'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    exp_q.push_back(model_sum(8'h02));
    accept_req(8'h02, a);
    chk("prio_accept_cycle", 32'(a - tw), 1);
    collect("prio", 0, a);

    // write during READ to a selected entry is ignored
    exp_q.push_back(model_sum(8'h02));
    accept_req(8'h02, a);
    wr_en = 1'b1; wr_seg = 2'd0; wr_idx = 2'd2; wr_data = 16'hBEEF;
    #1;
    chk("rdwr_wr_ready", wr_ready, 1'b0);
    repeat (3) @(negedge clk);
    wr_en = 1'b0;
    collect("rdwr", 0, a);

    // reset in the second READ cycle
    in_valid = 1'b1; in_idx = 8'hFF;
    accept_req(8'hFF, a);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_idle", {dbg_state, in_ready}, {2'd0, 1'b1});
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("midrst_no_valid", saw, 1'b0);
    run_req("midrst_fresh", 8'h93, model_sum(8'h93), 0);

    // back-to-back with prompt out_ready
    exp_q.push_back(model_sum(8'h1B));
    accept_req(8'h1B, a);
    collect("b2b_a", 0, a);
    exp_q.push_back(model_sum(8'hE4));
    accept_req(8'hE4, a2);
    chk("b2b_period", 32'(a2 - a), NS + 3);
    collect("b2b_b", 0, a2);

    // randomized against the reference model
    for (int r = 0; r < 8; r++) begin
      repeat (3) wr($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
      ri = 8'($urandom);
      run_req($sformatf("rand%0d", r), ri, model_sum(ri), $urandom_range(0, 3));
    end

    // widest sum: every entry 0xFFFF
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 4; i++) wr(s, i, 16'hFFFF);
    for (int r = 0; r < 2; r++) run_req($sformatf("ovf%0d", r), 8'($urandom), 18'h3FFFC, 0);

    // default parameters: 8 tables x 32 entries of 2^1024-1
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 32; i++) begin
        b_wr_en = 1'b1; b_wr_seg = 3'(s); b_wr_idx = 5'(i); b_wr_data = {1024{1'b1}};
        @(negedge clk);
      end
    b_wr_en = 1'b0;
    big_exp = '0;
    for (int k = 0; k < 8; k++) big_exp += {3'b000, {1024{1'b1}}};
    b_in_valid = 1'b1; b_in_idx = {8'($urandom), 32'($urandom)};
    #1;
    chk("big_in_ready", b_in_ready, 1'b1);
    a = cyc;
    @(negedge clk);
    b_in_valid = 1'b0;
    while (!b_out_valid && (cyc - a) < 40) @(negedge clk);
    chk("big_valid", b_out_valid, 1'b1);
    chk("big_lat", 32'(cyc - a), 10);
    chk("big_sum", b_out_sum, big_exp);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("big_idle", {b_out_valid, b_dbg_state}, {1'b0, 2'd0});

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
